// File: rtl/rosetta_load_sequencer.sv
// -----------------------------------------------------------------------------
// rosetta_load_sequencer
//
// Host-side sequencer in front of the ROSETTA ext wrapper. It accepts one load
// descriptor, burst-writes a 512b data stream into the AM0/AM1/WM/BM region
// over the 512b ext port, and can then kick the accelerator through the 32b
// CSR port and poll its status register until done or timeout.
//
// Ports
//   ext_clk, ext_rst        clock, asynchronous active-high reset
//   desc_*                  descriptor handshake (region, base beat, length,
//                           kick request)
//   s_valid/s_ready/s_data  512b stream input, one beat per cycle max
//   ext_*_512b              512b region write port (combinational from stream)
//   ext_*_32b               32b CSR port (kick write, status reads)
//   busy, done, err         status; done/err are one-cycle pulses
//   err_code                1 = range error, 2 = poll timeout; holds until
//                           the next descriptor is accepted
//
// Optional feature (macro ROSETTA_LDSEQ_PERF_EN)
//   Adds perf_cycles[31:0]: cycles from KICK through the cycle DONE is
//   entered, saturating, cleared on descriptor accept.
// -----------------------------------------------------------------------------
module rosetta_load_sequencer #(
  parameter int           REGION_BEATS  = 2048,
  parameter int           RD_LAT        = 1,
  parameter int           POLL_TIMEOUT  = 65535,
  parameter logic [11:0]  CSR_CTRL_ADDR = 12'h000,
  parameter logic [11:0]  CSR_STAT_ADDR = 12'h004,
  parameter int           START_BIT     = 0,
  parameter int           DONE_BIT      = 0
) (
  input  logic         ext_clk,
  input  logic         ext_rst,
  input  logic         desc_valid,
  output logic         desc_ready,
  input  logic [1:0]   desc_region,
  input  logic [10:0]  desc_base,
  input  logic [11:0]  desc_len,
  input  logic         desc_kick,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [511:0] s_data,
  output logic [18:0]  ext_addr_512b,
  output logic [511:0] ext_wdata_512b,
  output logic [63:0]  ext_we_512b,
  output logic         ext_en_512b,
  output logic [11:0]  ext_addr_32b,
  output logic [31:0]  ext_wdata_32b,
  output logic [3:0]   ext_we_32b,
  output logic         ext_en_32b,
  input  logic [31:0]  ext_rdata_32b,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code
`ifdef ROSETTA_LDSEQ_PERF_EN
  ,
  output logic [31:0]  perf_cycles
`endif
);

  // Poll counter must reach POLL_TIMEOUT; read-latency counter reaches RD_LAT-1.
  localparam int PW = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT + 1) : 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_KICK,
    S_POLL_REQ,
    S_POLL_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      region_q, region_d;
  logic [10:0]     ptr_q, ptr_d;
  logic [11:0]     rem_q, rem_d;
  logic            kick_q, kick_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [1:0]      err_code_q, err_code_d;
  // Holds desc_ready low through reset and for the first cycle after release.
  logic            rdy_q;

  logic            accept;
  logic [12:0]     end_beat;

  // Only DONE_BIT of the status word is meaningful.
  logic            unused_rdata;
  assign unused_rdata = ^ext_rdata_32b;

  // 13-bit sum so base + len cannot wrap before the range compare.
  assign end_beat = {2'b00, ptr_q} + {1'b0, rem_q};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge ext_clk or posedge ext_rst) begin
    if (ext_rst) begin
      state_q    <= S_IDLE;
      region_q   <= '0;
      ptr_q      <= '0;
      rem_q      <= '0;
      kick_q     <= 1'b0;
      poll_q     <= '0;
      lat_q      <= '0;
      err_code_q <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      kick_q     <= kick_d;
      poll_q     <= poll_d;
      lat_q      <= lat_d;
      err_code_q <= err_code_d;
      rdy_q      <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    region_d       = region_q;
    ptr_d          = ptr_q;
    rem_d          = rem_q;
    kick_d         = kick_q;
    poll_d         = poll_q;
    lat_d          = lat_q;
    err_code_d     = err_code_q;
    accept         = 1'b0;
    desc_ready     = 1'b0;
    s_ready        = 1'b0;
    ext_addr_512b  = '0;
    ext_wdata_512b = '0;
    ext_we_512b    = '0;
    ext_en_512b    = 1'b0;
    ext_addr_32b   = '0;
    ext_wdata_32b  = '0;
    ext_we_32b     = '0;
    ext_en_32b     = 1'b0;
    done           = 1'b0;
    err            = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        desc_ready = rdy_q;
        if (desc_valid && rdy_q) begin
          accept     = 1'b1;
          region_d   = desc_region;
          ptr_d      = desc_base;
          rem_d      = desc_len;
          kick_d     = desc_kick;
          err_code_d = 2'd0;
          state_d    = S_CHECK;
        end
      end

      S_CHECK: begin
        if (end_beat > 13'(REGION_BEATS)) begin
          err_code_d = 2'd1;
          state_d    = S_ERR;
        end else if (rem_q == 12'd0) begin
          state_d = kick_q ? S_KICK : S_DONE;
        end else begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        s_ready = 1'b1;
        // Stream passes straight through to the region port in the same cycle.
        if (s_valid) begin
          ext_en_512b    = 1'b1;
          ext_we_512b    = '1;
          ext_wdata_512b = s_data;
          ext_addr_512b  = {region_q, ptr_q, 6'b0};
          ptr_d          = ptr_q + 11'd1;
          rem_d          = rem_q - 12'd1;
          if (rem_q == 12'd1) begin
            state_d = kick_q ? S_KICK : S_DONE;
          end
        end
      end

      S_KICK: begin
        ext_en_32b    = 1'b1;
        ext_we_32b    = 4'hF;
        ext_addr_32b  = CSR_CTRL_ADDR;
        ext_wdata_32b = 32'(1) << START_BIT;
        poll_d        = '0;
        state_d       = S_POLL_REQ;
      end

      S_POLL_REQ: begin
        ext_en_32b   = 1'b1;
        ext_addr_32b = CSR_STAT_ADDR;
        poll_d       = poll_q + PW'(1);
        lat_d        = '0;
        state_d      = S_POLL_WAIT;
      end

      S_POLL_WAIT: begin
        // lat_q counts elapsed cycles since the strobe minus one; read data is
        // valid once RD_LAT cycles have passed.
        if (lat_q == LW'(RD_LAT - 1)) begin
          if (ext_rdata_32b[DONE_BIT]) begin
            state_d = S_DONE;
          end else if (poll_q == PW'(POLL_TIMEOUT)) begin
            err_code_d = 2'd2;
            state_d    = S_ERR;
          end else begin
            state_d = S_POLL_REQ;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign err_code = err_code_q;

`ifdef ROSETTA_LDSEQ_PERF_EN
  logic [31:0] perf_q;

  // Counts KICK and every poll cycle, including the one that moves to DONE.
  always_ff @(posedge ext_clk or posedge ext_rst) begin
    if (ext_rst) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if ((state_q == S_KICK || state_q == S_POLL_REQ ||
                  state_q == S_POLL_WAIT) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_rosetta_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rosetta_load_sequencer
//
// Table-driven bench: each vector is one descriptor with its stream-valid
// pattern, the status read on which the DONE bit appears, and hand-computed
// expectations. A hand-written sequence covers asynchronous reset mid-write.
// The DUT is built with POLL_TIMEOUT = 4 so the timeout path stays short.
// -----------------------------------------------------------------------------
module tb_rosetta_load_sequencer;

  logic         ext_clk;
  logic         ext_rst;
  logic         desc_valid;
  logic         desc_ready;
  logic [1:0]   desc_region;
  logic [10:0]  desc_base;
  logic [11:0]  desc_len;
  logic         desc_kick;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] s_data;
  logic [18:0]  ext_addr_512b;
  logic [511:0] ext_wdata_512b;
  logic [63:0]  ext_we_512b;
  logic         ext_en_512b;
  logic [11:0]  ext_addr_32b;
  logic [31:0]  ext_wdata_32b;
  logic [3:0]   ext_we_32b;
  logic         ext_en_32b;
  logic [31:0]  ext_rdata_32b;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   err_code;

  int n_checks = 0;
  int n_errors = 0;

  rosetta_load_sequencer #(
    .POLL_TIMEOUT (4)
  ) dut (
    .ext_clk        (ext_clk),
    .ext_rst        (ext_rst),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_region    (desc_region),
    .desc_base      (desc_base),
    .desc_len       (desc_len),
    .desc_kick      (desc_kick),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .ext_addr_512b  (ext_addr_512b),
    .ext_wdata_512b (ext_wdata_512b),
    .ext_we_512b    (ext_we_512b),
    .ext_en_512b    (ext_en_512b),
    .ext_addr_32b   (ext_addr_32b),
    .ext_wdata_32b  (ext_wdata_32b),
    .ext_we_32b     (ext_we_32b),
    .ext_en_32b     (ext_en_32b),
    .ext_rdata_32b  (ext_rdata_32b),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .err_code       (err_code)
  );

  initial ext_clk = 1'b0;
  always #5 ext_clk = ~ext_clk;

  typedef struct {
    string       nm;
    logic [1:0]  region;
    logic [10:0] base;
    logic [11:0] len;
    logic        kick;
    logic [7:0]  sv_pat;     // bit k: s_valid on the k-th s_ready cycle
    int          done_rd;    // status read that returns DONE (0 = never)
    int          exp_writes;
    logic [18:0] exp_addr0;
    bit          exp_done;
    logic [1:0]  exp_code;
    int          exp_csr_wr;
    int          exp_reads;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] beat_data(input logic [10:0] base, input int idx);
    return {16{(32'(base) << 16) | 32'(idx)}};
  endfunction

  // Starts and ends at one time unit after a rising edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    int  wr = 0, csr_wr = 0, rds = 0, sr_cyc = 0, k = 0;
    int  last_wr_cyc = -1, done_cyc = -1;
    int  excl_bad = 0, en_bad = 0, rdy_bad = 0;
    bit  fin = 0, got_done = 0, got_err = 0, rd_pend = 0;
    logic [31:0] resp = '0;
    logic [1:0]  code = '0;

    @(negedge ext_clk);
    check({v.nm, " desc_ready idle"}, 64'(desc_ready), 64'd1);
    desc_region = v.region;
    desc_base   = v.base;
    desc_len    = v.len;
    desc_kick   = v.kick;
    desc_valid  = 1'b1;
    @(posedge ext_clk);
    #1;
    desc_valid = 1'b0;

    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      ext_rdata_32b = rd_pend ? resp : 32'd0;
      rd_pend = 0;
      if (s_ready) begin
        s_valid = (k < 8) ? v.sv_pat[k] : 1'b1;
        k++;
      end else begin
        s_valid = 1'b0;
      end
      s_data = beat_data(v.base, wr);

      @(negedge ext_clk);
      if (ext_en_512b && ext_en_32b) excl_bad++;
      if (ext_en_512b != (s_valid && s_ready)) en_bad++;
      if (desc_ready) rdy_bad++;
      if (s_ready) sr_cyc++;
      if (ext_en_512b) begin
        check({v.nm, " addr"}, 64'(ext_addr_512b), 64'(v.exp_addr0 + 19'(64 * wr)));
        check({v.nm, " we512"}, ext_we_512b, 64'hFFFF_FFFF_FFFF_FFFF);
        check({v.nm, " wdata"}, 64'(ext_wdata_512b == beat_data(v.base, wr)), 64'd1);
        last_wr_cyc = cyc;
        wr++;
      end
      if (ext_en_32b) begin
        if (ext_we_32b == 4'hF) begin
          csr_wr++;
          check({v.nm, " kick addr"}, 64'(ext_addr_32b), 64'h000);
          check({v.nm, " kick data"}, 64'(ext_wdata_32b), 64'h1);
        end else begin
          rds++;
          check({v.nm, " poll addr"}, 64'(ext_addr_32b), 64'h004);
          check({v.nm, " poll we"}, 64'(ext_we_32b), 64'h0);
          rd_pend = 1;
          resp = (v.done_rd != 0 && rds >= v.done_rd) ? 32'h1 : 32'h0;
        end
      end
      if (done) begin
        got_done = 1;
        done_cyc = cyc;
        fin = 1;
      end
      if (err) begin
        got_err = 1;
        code = err_code;
        fin = 1;
      end
      @(posedge ext_clk);
      #1;
    end
    s_valid = 1'b0;
    ext_rdata_32b = '0;

    check({v.nm, " finished in budget"}, 64'(fin), 64'd1);
    check({v.nm, " done seen"}, 64'(got_done), 64'(v.exp_done));
    check({v.nm, " err seen"}, 64'(got_err), 64'(!v.exp_done));
    if (got_err) check({v.nm, " err_code at err"}, 64'(code), 64'(v.exp_code));
    check({v.nm, " writes"}, 64'(wr), 64'(v.exp_writes));
    check({v.nm, " csr writes"}, 64'(csr_wr), 64'(v.exp_csr_wr));
    check({v.nm, " status reads"}, 64'(rds), 64'(v.exp_reads));
    check({v.nm, " port exclusivity"}, 64'(excl_bad), 64'd0);
    check({v.nm, " en512 follows beat"}, 64'(en_bad), 64'd0);
    check({v.nm, " desc_ready low busy"}, 64'(rdy_bad), 64'd0);
    if (v.exp_code == 2'd1) check({v.nm, " no s_ready"}, 64'(sr_cyc), 64'd0);
    if (v.exp_writes > 0 && !v.kick)
      check({v.nm, " done after last beat"}, 64'(done_cyc), 64'(last_wr_cyc + 1));
    // One cycle after the pulse: back in IDLE, pulses gone, code held.
    check({v.nm, " busy after end"}, 64'(busy), 64'd0);
    check({v.nm, " pulse cleared"}, 64'({done, err}), 64'd0);
    check({v.nm, " err_code held"}, 64'(err_code), 64'(v.exp_code));
  endtask

  initial begin
    vec_t rv;
    int   cnt;

    //            name          rg   base    len     kk  pat    drd wr addr0        dn code cw rd
    vecs[0] = '{"stream",    2'd2, 11'd5,    12'd3,    0, 8'hFF, 0, 3, 19'h40140, 1, 2'd0, 0, 0};
    vecs[1] = '{"bubbles",   2'd1, 11'd100,  12'd2,    0, 8'h05, 0, 2, 19'h21900, 1, 2'd0, 0, 0};
    vecs[2] = '{"range",     2'd3, 11'd2047, 12'd2,    1, 8'hFF, 1, 0, 19'h00000, 0, 2'd1, 0, 0};
    vecs[3] = '{"kickpoll",  2'd0, 11'd0,    12'd0,    1, 8'hFF, 3, 0, 19'h00000, 1, 2'd0, 1, 3};
    vecs[4] = '{"timeout",   2'd0, 11'd0,    12'd0,    1, 8'hFF, 0, 0, 19'h00000, 0, 2'd2, 1, 4};
    vecs[5] = '{"exact_fit", 2'd0, 11'd2046, 12'd2,    1, 8'hFF, 1, 2, 19'h1FF80, 1, 2'd0, 1, 1};
    vecs[6] = '{"len0",      2'd3, 11'd7,    12'd0,    0, 8'hFF, 0, 0, 19'h00000, 1, 2'd0, 0, 0};
    vecs[7] = '{"last_beat", 2'd1, 11'd2047, 12'd1,    1, 8'h03, 2, 1, 19'h3FFC0, 1, 2'd0, 1, 2};
    vecs[8] = '{"big_range", 2'd2, 11'd2047, 12'd4095, 0, 8'hFF, 0, 0, 19'h00000, 0, 2'd1, 0, 0};

    ext_rst       = 1'b1;
    desc_valid    = 1'b0;
    desc_region   = '0;
    desc_base     = '0;
    desc_len      = '0;
    desc_kick     = 1'b0;
    s_valid       = 1'b0;
    s_data        = '0;
    ext_rdata_32b = '0;

    #2;
    check("reset desc_ready", 64'(desc_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset enables", 64'({ext_en_512b, ext_en_32b, s_ready}), 64'd0);
    check("reset pulses", 64'({done, err, err_code}), 64'd0);
    #20;
    ext_rst = 1'b0;
    #1;
    check("desc_ready before first edge", 64'(desc_ready), 64'd0);
    @(posedge ext_clk);
    #1;
    check("desc_ready after first edge", 64'(desc_ready), 64'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of a 4-beat write after one beat.
    @(negedge ext_clk);
    desc_region = 2'd2;
    desc_base   = 11'd10;
    desc_len    = 12'd4;
    desc_kick   = 1'b0;
    desc_valid  = 1'b1;
    @(posedge ext_clk);
    #1;
    desc_valid = 1'b0;
    cnt = 0;
    while (!s_ready && cnt < 10) begin
      @(posedge ext_clk);
      #1;
      cnt++;
    end
    check("arst reached write", 64'(s_ready), 64'd1);
    s_valid = 1'b1;
    s_data  = {16{32'hCAFE_0001}};
    @(negedge ext_clk);
    check("arst first beat en", 64'(ext_en_512b), 64'd1);
    check("arst first beat addr", 64'(ext_addr_512b), 64'h40280);
    @(posedge ext_clk);
    #1;
    check("arst second beat offered", 64'(ext_en_512b), 64'd1);
    #2;
    ext_rst = 1'b1;
    #1;
    check("arst en512 drops", 64'(ext_en_512b), 64'd0);
    check("arst we512 drops", ext_we_512b, 64'd0);
    check("arst s_ready drops", 64'(s_ready), 64'd0);
    check("arst busy drops", 64'(busy), 64'd0);
    s_valid = 1'b0;
    @(posedge ext_clk);
    #1;
    ext_rst = 1'b0;
    @(posedge ext_clk);
    #1;
    check("arst ready again", 64'(desc_ready), 64'd1);
    rv = '{"after_rst", 2'd2, 11'd20, 12'd2, 0, 8'hFF, 0, 2, 19'h40500, 1, 2'd0, 0, 0};
    run_vec(rv);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
